// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch slice.
package fetch_stage_pkg;

  localparam int unsigned MEM_SIZE = 512;
  localparam int unsigned ADDR_W   = 9;

  typedef logic [31:0]       word_t;
  typedef logic [ADDR_W-1:0] address_t;

  localparam word_t NOP_INSTR  = 32'h0000_0013;
  localparam word_t IMEM_BYTES = word_t'(MEM_SIZE * 4);

  typedef enum logic [1:0] {IDLE, RUN, HALT} fetch_state_e;

  typedef enum logic [1:0] {PC_HOLD, PC_INC, PC_REDIRECT} pc_sel_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-to-decode handshake: registered instruction, its PC and link value.
interface fetch_stage_if
  import fetch_stage_pkg::*;
  ;
  logic  if_valid;
  logic  if_ready;
  word_t if_instr;
  word_t if_pc;
  word_t if_pc_plus4;

  modport master (
    output if_valid, if_instr, if_pc, if_pc_plus4,
    input  if_ready
  );

  modport slave (
    input  if_valid, if_instr, if_pc, if_pc_plus4,
    output if_ready
  );
endinterface

// File: rtl/pc_next_sel.sv
// Next-PC mux plus redirect-alignment and fetch-range checks.
module pc_next_sel
  import fetch_stage_pkg::*;
(
  input  pc_sel_e sel,
  input  word_t   pc,
  input  word_t   redirect_pc,
  output word_t   pc_next,
  output word_t   pc_plus4,
  output logic    redirect_misaligned,
  output logic    pc_out_of_range
);

  always_comb begin
    pc_plus4            = pc + 32'd4;
    redirect_misaligned = (redirect_pc[1:0] != 2'b00);
    // A wrapped pc+4 can never be reached: the range fault fires first.
    pc_out_of_range     = (pc >= IMEM_BYTES);
    pc_next             = pc;
    case (sel)
      PC_INC:      pc_next = pc_plus4;
      PC_REDIRECT: pc_next = redirect_pc;
      default:     pc_next = pc;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives instr_mem, registers the
// fetched word toward decode, and halts on misaligned/out-of-range targets.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter word_t RESET_PC  = 32'h0000_0000,
  parameter word_t NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  redirect_valid,
  input  word_t                 redirect_pc,
  output address_t              imem_addr,
  input  word_t                 imem_instr,
  fetch_stage_if.master         if_bus,
  output logic                  fault,
  output word_t                 fault_pc
);

  fetch_state_e state_q, state_d;
  word_t        pc_q, pc_d, pc_plus4;
  pc_sel_e      sel;
  logic         misaligned, out_of_range;

  logic         valid_q, valid_d;
  word_t        instr_q, instr_d;
  word_t        ipc_q, ipc_d;
  word_t        ipc4_q, ipc4_d;
  logic         fault_q, fault_d;
  word_t        fault_pc_q, fault_pc_d;

  pc_next_sel u_pc_next_sel (
    .sel                 (sel),
    .pc                  (pc_q),
    .redirect_pc         (redirect_pc),
    .pc_next             (pc_d),
    .pc_plus4            (pc_plus4),
    .redirect_misaligned (misaligned),
    .pc_out_of_range     (out_of_range)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
      instr_q    <= NOP_INSTR;
      ipc_q      <= '0;
      ipc4_q     <= 32'd4;
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      ipc_q      <= ipc_d;
      ipc4_q     <= ipc4_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sel        = PC_HOLD;
    valid_d    = valid_q;
    instr_d    = instr_q;
    ipc_d      = ipc_q;
    ipc4_d     = ipc4_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
    case (state_q)
      IDLE: state_d = RUN;
      RUN: begin
        // Redirect outranks both a fire and a stall: the held word is squashed.
        if (redirect_valid) begin
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          if (misaligned) begin
            state_d    = HALT;
            fault_d    = 1'b1;
            fault_pc_d = redirect_pc;
          end else begin
            sel = PC_REDIRECT;
          end
        end else if (!valid_q || if_bus.if_ready) begin
          if (out_of_range) begin
            state_d    = HALT;
            fault_d    = 1'b1;
            fault_pc_d = pc_q;
            valid_d    = 1'b0;
          end else begin
            sel     = PC_INC;
            valid_d = 1'b1;
            instr_d = imem_instr;
            ipc_d   = pc_q;
            ipc4_d  = pc_plus4;
          end
        end
      end
      HALT: begin
        valid_d = 1'b0;
        if (redirect_valid) begin
          if (misaligned) begin
            fault_pc_d = redirect_pc;
          end else begin
            fault_d = 1'b0;
            sel     = PC_REDIRECT;
            state_d = RUN;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign imem_addr          = pc_q[10:2];
  assign if_bus.if_valid    = valid_q;
  assign if_bus.if_instr    = instr_q;
  assign if_bus.if_pc       = ipc_q;
  assign if_bus.if_pc_plus4 = ipc4_q;
  assign fault              = fault_q;
  assign fault_pc           = fault_pc_q;

endmodule
